clk_div_prog: RTL and testbench
===============================

# clk_div_prog

Programmable clock divider and period-tick generator for the timer-control path. It divides `clk_in` by a runtime-loadable ratio with a runtime-loadable high time, and emits a one-cycle `tick` at the end of every period. It supports continuous and one-shot modes. It replaces the fixed divide-by-100 stage, so the countdown, display and beeper timebases all come from one block.

## Interface
- `WIDTH`, 16: width of the counter and configuration words.
- `DEFAULT_DIV`, 100: period in `clk_in` cycles after reset.
- `DEFAULT_HIGH`, 50: high time in cycles after reset.

Ports:
- `clk_in`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  run enable, level-sensitive.
- `oneshot`  in  1  mode select, sampled on the IDLE→RUN transition: 1 = single period, 0 = continuous.
- `load`  in  1  single-cycle strobe that captures `div_in` and `high_in` into the shadow registers.
- `div_in`  in  WIDTH  requested period.
- `high_in`  in  WIDTH  requested high cycles per period.
- `clk_out`  out  1  divided clock, registered.
- `tick`  out  1  registered; 1 in the last cycle of each period.
- `done`  out  1  registered; 1 while in HOLD.
- `busy`  out  1  registered; 1 while in RUN.

## Operation
- States:
  - IDLE: `cnt`=0, `clk_out`=0.
  - RUN: counting.
  - HOLD: one-shot period finished.
- Transitions:
  - IDLE→RUN when `en`=1. The one-shot flag is latched at this edge.
  - RUN→IDLE when `en`=0, from any count.
  - RUN→HOLD at the end of a period when the latched one-shot flag is 1.
  - HOLD→IDLE when `en`=0.
- Counter: `cnt` runs 0..`div_r`-1, then wraps to 0 (continuous mode). It never exceeds `div_r`-1.
- Output waveform:
  - `clk_out` is 1 iff `cnt` ≥ `div_r`-`high_r`, so each period is low first, then high.
  - The registered value always matches the `cnt` held in the same cycle.
- Config clamps, applied when shadow values become active:
  - `div_r` = max(`div_in`, 2).
  - `high_r` = min(`high_in`, `div_r`-1).
  - `high_r`=0 gives a constant-low `clk_out` with `tick` still running.
- Config update:
  - `load` sets a pending flag and captures the shadow values; a later `load` overwrites them.
  - Pending values become active at the next period boundary (the edge after the `tick` cycle), or on the next edge while in IDLE or HOLD.
  - A period is never truncated by a config change.
- Simultaneous events:
  - `load` in the `tick` cycle: the new values apply to the immediately following period.
  - `en`=0 in the `tick` cycle: go to IDLE; no HOLD is entered.
- `tick` is asserted only in RUN, in the cycle with `cnt`=`div_r`-1.

## Timing
- Reset (asynchronous, any time, including mid-period):
  - State IDLE, `cnt`=0.
  - `div_r`=`DEFAULT_DIV`, `high_r`=`DEFAULT_HIGH`, pending flag cleared.
  - `clk_out`=0, `tick`=0, `done`=0, `busy`=0.
- Start:
  - The edge sampling `en`=1 enters RUN; `cnt`=0 is held for that first RUN cycle.
  - Each RUN cycle then adds 1, so a period is exactly `div_r` cycles.
- `busy` rises on the same edge RUN is entered.
- One-shot: `done` rises on the edge after the `tick` cycle, with `clk_out`=0, and stays 1 until `en` falls.
- Stop: the edge sampling `en`=0 forces `clk_out`=0 and `cnt`=0 in the same update.

## Structure
- Shared package `clk_div_pkg` holds:
  - state encodings IDLE/RUN/HOLD as localparams;
  - clamp helper functions for the div and high values;
  - the default constants used by the timer-control top.
- Sub-module `clk_div_cfg`: shadow registers, pending flag and clamp logic. It outputs `div_r` and `high_r` and takes an apply strobe from the FSM.

## Test plan
- Reset, then `en`=1 with defaults → `clk_out` low for `cnt` 0..49 and high for 50..99. Period is exactly 100 cycles; `tick` comes every 100 cycles.
- `load` with `div_in`=10, `high_in`=3 at `cnt`=20 → the current 100-cycle period completes. The next period is 7 cycles low, then 3 cycles high.
- `oneshot`=1, `div_in`=4, `high_in`=2 → one period of 2 cycles low and 2 high, one `tick`. `done`=1 with `clk_out`=0 until `en` falls, then IDLE.
- Clamp cases:
  - `div_in`=0 → period 2.
  - `div_in`=5, `high_in`=9 → 1 cycle low, 4 cycles high.
  - `high_in`=0 → `clk_out` constant 0 while `tick` continues.
- `rst_n` asserted mid-period at `cnt`=73 → all outputs 0 immediately and defaults restored. Restart yields a full 100-cycle period.
- `en` dropped in the `tick` cycle in one-shot mode → IDLE, `done` never asserts.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared encodings, reset defaults and config clamp helpers for the
// programmable clock divider.
package clk_div_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam int DEF_DIV  = 100;
  localparam int DEF_HIGH = 50;

  // A period shorter than 2 cycles has no room for both a low and a high phase.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < 32'd2) ? 32'd2 : d;
  endfunction

  // At least one low cycle per period, so the period start stays visible.
  function automatic logic [31:0] clamp_high(input logic [31:0] h, input logic [31:0] d);
    return (h > d - 32'd1) ? d - 32'd1 : h;
  endfunction

endpackage

// File: rtl/clk_div_cfg.sv
// Shadow/active config registers for clk_div_prog. Pending values are clamped
// and become active only on an apply strobe; a load on that same edge bypasses the shadow.
module clk_div_cfg
  import clk_div_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int DEFAULT_DIV  = DEF_DIV,
  parameter int DEFAULT_HIGH = DEF_HIGH
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  input  logic [WIDTH-1:0] high_in,
  input  logic             apply,
  output logic [WIDTH-1:0] div_r,
  output logic [WIDTH-1:0] high_r,
  output logic [WIDTH-1:0] div_nx,
  output logic [WIDTH-1:0] high_nx
);

  logic [WIDTH-1:0] div_sh, high_sh, src_div, src_high, cl_div, cl_high;
  logic             pend;

  always_comb begin
    src_div  = load ? div_in  : div_sh;
    src_high = load ? high_in : high_sh;
    cl_div   = WIDTH'(clamp_div(32'(src_div)));
    cl_high  = WIDTH'(clamp_high(32'(src_high), 32'(cl_div)));
    div_nx   = div_r;
    high_nx  = high_r;
    if (apply && (load || pend)) begin
      div_nx  = cl_div;
      high_nx = cl_high;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_r   <= WIDTH'(DEFAULT_DIV);
      high_r  <= WIDTH'(DEFAULT_HIGH);
      div_sh  <= WIDTH'(DEFAULT_DIV);
      high_sh <= WIDTH'(DEFAULT_HIGH);
      pend    <= 1'b0;
    end else begin
      div_r  <= div_nx;
      high_r <= high_nx;
      pend   <= (pend || load) && !apply;
      if (load) begin
        div_sh  <= div_in;
        high_sh <= high_in;
      end
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock divider / period-tick generator with continuous and
// one-shot modes. All outputs are registered from the next-state values.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int DEFAULT_DIV  = DEF_DIV,
  parameter int DEFAULT_HIGH = DEF_HIGH
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             oneshot,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  input  logic [WIDTH-1:0] high_in,
  output logic             clk_out,
  output logic             tick,
  output logic             done,
  output logic             busy
);

  logic [1:0]       state, st_nx;
  logic [WIDTH-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] div_r, high_r, div_nx, high_nx;
  logic             os_r, last, apply;

  assign last  = (cnt == div_r - WIDTH'(1));
  // Config may only change between periods, or whenever the counter is parked.
  assign apply = (state != ST_RUN) || last;

  clk_div_cfg #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV),
    .DEFAULT_HIGH(DEFAULT_HIGH)
  ) u_cfg (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .load   (load),
    .div_in (div_in),
    .high_in(high_in),
    .apply  (apply),
    .div_r  (div_r),
    .high_r (high_r),
    .div_nx (div_nx),
    .high_nx(high_nx)
  );

  always_comb begin
    st_nx  = state;
    cnt_nx = cnt;
    case (state)
      ST_IDLE: if (en) st_nx = ST_RUN;
      ST_RUN: begin
        if (!en) begin
          st_nx  = ST_IDLE;
          cnt_nx = '0;
        end else if (last) begin
          cnt_nx = '0;
          if (os_r) st_nx = ST_HOLD;
        end else begin
          cnt_nx = cnt + WIDTH'(1);
        end
      end
      ST_HOLD: if (!en) st_nx = ST_IDLE;
      default: begin
        st_nx  = ST_IDLE;
        cnt_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      os_r    <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= st_nx;
      cnt     <= cnt_nx;
      if (state == ST_IDLE && en) os_r <= oneshot;
      // Waveform is derived from the same count/config that will be held next cycle.
      clk_out <= (st_nx == ST_RUN) && (cnt_nx >= div_nx - high_nx);
      tick    <= (st_nx == ST_RUN) && (cnt_nx == div_nx - WIDTH'(1));
      done    <= (st_nx == ST_HOLD);
      busy    <= (st_nx == ST_RUN);
    end
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: measures period length and low/high split
// per period against hand-computed values.
module tb_clk_div_prog;

  logic        clk_in = 1'b0;
  logic        rst_n, en, oneshot, load;
  logic [15:0] div_in, high_in;
  logic        clk_out, tick, done, busy;
  int          n_err = 0, n_chk = 0;
  int          len, lo, hi, obad, acc;

  clk_div_prog #(.WIDTH(16), .DEFAULT_DIV(100), .DEFAULT_HIGH(50)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .en     (en),
    .oneshot(oneshot),
    .load   (load),
    .div_in (div_in),
    .high_in(high_in),
    .clk_out(clk_out),
    .tick   (tick),
    .done   (done),
    .busy   (busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Samples one period starting at its first cycle; returns at the tick cycle.
  task automatic measure(input int ld_at, input logic [15:0] ld_d, input logic [15:0] ld_h,
                         input bit drop, output int l, output int nlo, output int nhi,
                         output int ob);
    bit seen_hi = 1'b0;
    l = 0; nlo = 0; nhi = 0; ob = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_in);
      load = 1'b0;
      l++;
      if (clk_out) begin
        nhi++;
        seen_hi = 1'b1;
      end else begin
        nlo++;
        if (seen_hi) ob = 1;
      end
      if (i == ld_at) begin
        load = 1'b1; div_in = ld_d; high_in = ld_h;
      end
      if (tick) begin
        if (drop) en = 1'b0;
        break;
      end
    end
  endtask

  task automatic start_cfg(input logic [15:0] d, input logic [15:0] h, input logic os);
    load = 1'b1; div_in = d; high_in = h; oneshot = os;
    @(negedge clk_in);
    load = 1'b0; en = 1'b1;
  endtask

  task automatic per(input string tag, input int el, input int elo, input int ehi);
    chk({tag, "_len"}, len, el);
    chk({tag, "_lo"}, lo, elo);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_order"}, obad, 0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; oneshot = 1'b0; load = 1'b0; div_in = '0; high_in = '0;
    #3;
    chk("rst_clk", clk_out, 0); chk("rst_tick", tick, 0);
    chk("rst_done", done, 0);   chk("rst_busy", busy, 0);
    @(negedge clk_in); rst_n = 1'b1;
    @(negedge clk_in); en = 1'b1;

    // Defaults: 50 low, 50 high.
    measure(-1, 0, 0, 0, len, lo, hi, obad);
    per("def", 100, 50, 50);
    chk("def_busy", busy, 1);
    // Load mid-period: current period untouched, next is 7 low / 3 high.
    measure(20, 16'd10, 16'd3, 0, len, lo, hi, obad);
    per("ld_cur", 100, 50, 50);
    measure(-1, 0, 0, 1, len, lo, hi, obad);
    per("ld_new", 10, 7, 3);
    @(negedge clk_in);
    chk("stop_busy", busy, 0); chk("stop_clk", clk_out, 0);

    // One-shot 4/2.
    start_cfg(16'd4, 16'd2, 1'b1);
    measure(-1, 0, 0, 0, len, lo, hi, obad);
    per("os", 4, 2, 2);
    acc = 0;
    repeat (5) begin
      @(negedge clk_in);
      acc += done + 2 * clk_out + 4 * tick + 8 * busy;
    end
    chk("os_hold", acc, 5);
    en = 1'b0;
    @(negedge clk_in);
    chk("os_idle_done", done, 0); chk("os_idle_busy", busy, 0);

    // Clamp cases.
    start_cfg(16'd0, 16'd1, 1'b0);
    measure(-1, 0, 0, 1, len, lo, hi, obad);
    per("cl_div0", 2, 1, 1);
    start_cfg(16'd5, 16'd9, 1'b0);
    measure(-1, 0, 0, 1, len, lo, hi, obad);
    per("cl_high", 5, 1, 4);
    start_cfg(16'd6, 16'd0, 1'b0);
    measure(-1, 0, 0, 0, len, lo, hi, obad);
    per("cl_h0a", 6, 6, 0);
    measure(-1, 0, 0, 1, len, lo, hi, obad);
    per("cl_h0b", 6, 6, 0);

    // Async reset at cnt=73 of a 120/100 period (clk_out already high).
    start_cfg(16'd120, 16'd100, 1'b0);
    repeat (74) @(negedge clk_in);
    chk("pre_rst_clk", clk_out, 1); chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_clk", clk_out, 0); chk("mid_rst_busy", busy, 0);
    chk("mid_rst_tick", tick, 0);   chk("mid_rst_done", done, 0);
    @(negedge clk_in); rst_n = 1'b1;
    measure(-1, 0, 0, 1, len, lo, hi, obad);
    per("post_rst", 100, 50, 50);

    // One-shot with en dropped in the tick cycle: straight to IDLE.
    start_cfg(16'd3, 16'd1, 1'b1);
    measure(-1, 0, 0, 1, len, lo, hi, obad);
    per("os_drop", 3, 2, 1);
    acc = 0;
    repeat (4) begin
      @(negedge clk_in);
      acc += done + 2 * busy;
    end
    chk("os_drop_nodone", acc, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
